comma_frame_tx: RTL
===================

COMMA_FRAME_TX -- requirements
Module: comma_frame_tx

Interface
REQ-001 Parameter word_size, default 16, payload width in bits.
REQ-002 Parameter count_size, default 5, bit-counter width; SHALL satisfy 2^count_size > word_size.
REQ-003 trigger  input  1  clock; all state changes on rising edge.
REQ-004 reset_n  input  1  synchronous, active-low reset, sampled on rising edge of trigger.
REQ-005 word_in  input  word_size  payload to transmit, sampled only when a load is accepted.
REQ-006 load  input  1  request to start a frame.
REQ-007 busy  output  1  high while a frame is in progress; load ignored while high.
REQ-008 serial_out  output  1  registered serial line.
REQ-009 done  output  1  one-cycle pulse after the final frame bit.

Function
REQ-010 Frame SHALL be: comma pattern 1,0,1 (3 bits), then word_in MSB first (word_size bits), then optional parity bit (REQ-022).
REQ-011 States SHALL be IDLE, COMMA, DATA and PARITY (PARITY only when compiled in).
REQ-012 IDLE: serial_out=0, busy=0; load=1 at a rising edge SHALL capture word_in into a shift register and go to COMMA.
REQ-013 Latency: first comma bit (1) SHALL appear on serial_out in the cycle immediately after the accepting edge.
REQ-014 COMMA: serial_out SHALL be 1, 0, 1 on three consecutive cycles, then go to DATA.
REQ-015 DATA: serial_out SHALL present captured bit word_size-1 down to 0, one per cycle; bit counter SHALL count 0..word_size-1 and not wrap mid-frame.
REQ-016 After the last data bit (or the parity bit if enabled), the FSM SHALL return to IDLE with serial_out=0 and done=1 for exactly that one cycle.
REQ-017 busy SHALL equal (state != IDLE); it SHALL be high from the cycle after acceptance through the last frame bit.
REQ-018 load while busy=1 SHALL be ignored, with no queuing; word_in changes while busy SHALL not affect the frame.
REQ-019 load=1 in the done cycle SHALL be accepted, so back-to-back frames are separated by exactly one idle cycle.
REQ-020 Frame length SHALL be word_size+3 cycles (word_size+4 with parity); 19 or 20 at the default.

Reset
REQ-021 reset_n=0 at a rising edge SHALL force IDLE: serial_out=0, busy=0, done=0, bit counter=0, shift register=0. Reset mid-frame SHALL abort the frame with no done pulse, and reset SHALL take priority over load.

Configuration
REQ-022 With COMMA_FRAME_TX_PARITY_EN defined, the FSM SHALL go DATA->PARITY and transmit one even-parity bit (XOR of the captured payload) before done. Without it, PARITY and its logic SHALL be absent and DATA->IDLE directly.

Structure
REQ-023 Package comma_pkg SHALL hold the comma pattern constant (3'b101), comma length (3) and state encodings. The receiving comma detector shares it.
REQ-024 One sub-module SHALL be natural: comma_bit_counter, a loadable up-counter with terminal-count flag, used for the COMMA and DATA phases.

Verification
REQ-025 Reset, then load=1 with word_in=16'h0005 -> serial_out 1,0,1,0000000000000101, then done pulse; busy high for 19 cycles.
REQ-026 Two loads of 16'hA0F0: first in IDLE, second in its done cycle -> two complete frames with one idle 0 cycle between them.
REQ-027 load pulsed and word_in changed to 16'hFFFF at cycle 5 of a 16'h0000 frame -> frame completes all-zero payload; second load ignored.
REQ-028 reset_n=0 in cycle 10 of a 16'hFFFF frame -> next cycle serial_out=0, busy=0, no done; a fresh load then sends a complete frame.
REQ-029 PARITY_EN defined, word_in=16'h0007 -> 20-bit frame ending in parity 1; word_in=16'h0003 -> parity 0.
REQ-030 load=1 and reset_n=0 on the same edge -> stays IDLE, busy=0.

Source files
------------

// File: rtl/comma_pkg.sv
// Shared framing constants and state encodings for the comma transmitter and
// the matching receive-side comma detector.
package comma_pkg;

  localparam logic [2:0] COMMA_PAT   = 3'b101;
  localparam int         COMMA_LEN   = 3;
  localparam logic       COMMA_FIRST = COMMA_PAT[2];

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COMMA  = 2'd1,
    DATA   = 2'd2,
    PARITY = 2'd3
  } state_t;

endpackage

// File: rtl/comma_bit_counter.sv
// Loadable up-counter with a terminal-count flag; the terminal value is supplied
// per phase by the owner so one counter serves both the comma and data phases.
module comma_bit_counter #(
  parameter int count_size = 5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load,
  input  logic [count_size-1:0] load_value,
  input  logic                  enable,
  input  logic [count_size-1:0] last,
  output logic [count_size-1:0] count,
  output logic                  tc
);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == last);

endmodule

// File: rtl/comma_frame_tx.sv
// Serial frame transmitter: comma 1,0,1 then payload MSB first, then done pulse.
// Define COMMA_FRAME_TX_PARITY_EN to append an even-parity bit after the payload.
//
//   state  | meaning
//   IDLE   | line low, waiting for load
//   COMMA  | sending the 3-bit comma pattern
//   DATA   | sending the captured payload, MSB first
//   PARITY | sending the even-parity bit (parity builds only)
module comma_frame_tx
  import comma_pkg::*;
#(
  parameter int word_size  = 16,
  parameter int count_size = 5
) (
  input  logic                 trigger,
  input  logic                 reset_n,
  input  logic [word_size-1:0] word_in,
  input  logic                 load,
  output logic                 busy,
  output logic                 serial_out,
  output logic                 done
);

  state_t                state;
  logic [word_size-1:0]  shreg;
  logic [count_size-1:0] cnt;
  logic [count_size-1:0] cnt_last;
  logic                  cnt_tc;
  logic                  cnt_clear;
  logic                  cnt_en;
  logic                  comma_next;
`ifdef COMMA_FRAME_TX_PARITY_EN
  logic                  parity_bit;
`endif

  assign busy = (state != IDLE);

  always_comb begin
    cnt_last  = count_size'(word_size - 1);
    cnt_clear = 1'b0;
    cnt_en    = 1'b0;
    if (state == COMMA) cnt_last = count_size'(COMMA_LEN - 1);
    if (state == IDLE) begin
      cnt_clear = load;
    end else if (state == COMMA || state == DATA) begin
      cnt_clear = cnt_tc;
      cnt_en    = !cnt_tc;
    end
  end

  // Comma bit to present next, given the index currently on the line.
  always_comb begin
    case (cnt)
      count_size'(0): comma_next = COMMA_PAT[1];
      count_size'(1): comma_next = COMMA_PAT[0];
      default:        comma_next = COMMA_PAT[2];
    endcase
  end

  comma_bit_counter #(.count_size(count_size)) u_counter (
    .clk        (trigger),
    .reset_n    (reset_n),
    .load       (cnt_clear),
    .load_value ('0),
    .enable     (cnt_en),
    .last       (cnt_last),
    .count      (cnt),
    .tc         (cnt_tc)
  );

  always_ff @(posedge trigger) begin
    if (!reset_n) begin
      state      <= IDLE;
      shreg      <= '0;
      serial_out <= 1'b0;
      done       <= 1'b0;
`ifdef COMMA_FRAME_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          serial_out <= 1'b0;
          if (load) begin
            shreg      <= word_in;
            state      <= COMMA;
            serial_out <= COMMA_FIRST;
`ifdef COMMA_FRAME_TX_PARITY_EN
            parity_bit <= ^word_in;
`endif
          end
        end
        COMMA: begin
          if (cnt_tc) begin
            state      <= DATA;
            serial_out <= shreg[word_size-1];
            shreg      <= {shreg[word_size-2:0], 1'b0};
          end else begin
            serial_out <= comma_next;
          end
        end
        DATA: begin
          if (cnt_tc) begin
`ifdef COMMA_FRAME_TX_PARITY_EN
            state      <= PARITY;
            serial_out <= parity_bit;
`else
            state      <= IDLE;
            serial_out <= 1'b0;
            done       <= 1'b1;
`endif
          end else begin
            serial_out <= shreg[word_size-1];
            shreg      <= {shreg[word_size-2:0], 1'b0};
          end
        end
`ifdef COMMA_FRAME_TX_PARITY_EN
        PARITY: begin
          state      <= IDLE;
          serial_out <= 1'b0;
          done       <= 1'b1;
        end
`endif
        default: begin
          state      <= IDLE;
          serial_out <= 1'b0;
        end
      endcase
    end
  end

endmodule
